// File: rtl/ascon_pack.sv
// ascon_pack: shared Ascon types and constants
package ascon_pack;
    typedef logic [63:0] u64_t;
    typedef logic [31:0] u32_t;
    localparam int IN_FIFO_DEPTH_AW = 4;
    typedef enum logic {WAIT_HI, WAIT_LO} pack_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: 64-bit circular buffer with show-ahead head, flush and registered level
module sync_fifo
    import ascon_pack::*;
#(
    parameter int AW = IN_FIFO_DEPTH_AW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  u64_t        din,
    input  logic        pop,
    input  logic        flush,
    output u64_t        dout,
    output logic        empty,
    output logic        full,
    output logic [AW:0] level
);
    u64_t        mem [2**AW];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        end else begin
            wr_ptr <= flush ? '0 : wr_ptr + (AW+1)'(do_push);
            rd_ptr <= flush ? '0 : rd_ptr + (AW+1)'(do_pop);
            level  <= flush ? '0 : level + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (do_push) mem[wr_ptr[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/ascon_in_fifo.sv
// ascon_in_fifo: packs host word pairs into 64-bit entries for the core's AD/PT FIFO port
module ascon_in_fifo
    import ascon_pack::*;
#(
    parameter int DEPTH_AW = IN_FIFO_DEPTH_AW,
    parameter int WORD_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    input  logic              pop_i,
    input  logic              flush_i,
    output u64_t              data_o,
    output logic              empty_o,
    output logic [DEPTH_AW:0] level_o,
    output logic              half_pending_o,
    output logic              underflow_o
);
    pack_state_t state;
    pack_state_t state_nxt;
    u32_t        hold;
    logic        full;
    logic        hs;
    assign hs             = wr_valid_i && wr_ready_o;
    assign wr_ready_o     = !full || state == WAIT_HI;
    assign half_pending_o = state == WAIT_LO;
    always_comb begin
        state_nxt = state;
        if (flush_i) state_nxt = WAIT_HI;
        else if (hs) state_nxt = (state == WAIT_HI) ? WAIT_LO : WAIT_HI;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_HI;
            hold        <= '0;
            underflow_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            underflow_o <= !flush_i && (underflow_o || (pop_i && empty_o));
            if (hs && !flush_i && state == WAIT_HI) hold <= wr_data_i;
        end
    end
    sync_fifo #(.AW(DEPTH_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (hs && state == WAIT_LO),
        .din   ({hold, wr_data_i}),
        .pop   (pop_i),
        .flush (flush_i),
        .dout  (data_o),
        .empty (empty_o),
        .full  (full),
        .level (level_o)
    );
endmodule
